// File: rtl/frame_writer_pkg.sv
// Shared types for the frame-buffer write arbiter: frame-sequencing states and index sizing.
package frame_writer_pkg;

  typedef enum logic [1:0] {
    START,
    DRAW,
    FLUSH,
    SWAP_WAIT
  } state_t;

  // Width of a client index; never zero so a single-client build still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_writer_arbiter_rr.sv
// Round-robin pick among N requesters starting at ptr; combinational, one-hot grant plus winner index.
// No internal state: the caller owns the pointer and any backpressure.
module rr_arbiter
  import frame_writer_pkg::*;
#(
  parameter int N = 3,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/frame_writer_arbiter.sv
// Sequences frames and shares the frame-buffer write port round-robin; grant is combinational,
// write lands one cycle after the transfer, and ce=0 freezes state while suppressing grants/pulses.
module frame_writer_arbiter
  import frame_writer_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int N_CLIENTS         = 3,
  localparam int WR_ADDR_WIDTH    = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ce,
  input  logic [N_CLIENTS-1:0]               client_req,
  input  logic [N_CLIENTS*WR_ADDR_WIDTH-1:0] client_addr,
  input  logic [N_CLIENTS-1:0]               client_data,
  input  logic [N_CLIENTS-1:0]               client_done,
  output logic [N_CLIENTS-1:0]               client_gnt,
  output logic                               start,
  output logic                               swap_req,
  input  logic                               swap_ack,
  output logic                               wr_en,
  output logic [WR_ADDR_WIDTH-1:0]           wr_addr,
  output logic                               wr_data,
  output logic                               oob_err
);

  localparam int IW = idx_width(N_CLIENTS);
  localparam int unsigned FRAME_PIXELS = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;

  state_t                   state, state_nxt;
  logic [N_CLIENTS-1:0]     done_latch;
  logic [IW-1:0]            ptr, ptr_nxt;
  logic [N_CLIENTS-1:0]     arb_req;
  logic [IW-1:0]            win_idx;
  logic [WR_ADDR_WIDTH-1:0] win_addr;
  logic                     win_data;
  logic                     xfer;
  logic                     oob;

  rr_arbiter #(.N(N_CLIENTS)) u_rr (
    .req (arb_req),
    .ptr (ptr),
    .gnt (client_gnt),
    .idx (win_idx)
  );

  // A client that has reported done drops out of arbitration until the next frame.
  assign arb_req  = (state == DRAW && ce) ? (client_req & ~done_latch) : '0;
  assign xfer     = |client_gnt;
  assign win_addr = client_addr[win_idx*WR_ADDR_WIDTH +: WR_ADDR_WIDTH];
  assign win_data = client_data[win_idx];
  assign oob      = 32'(win_addr) >= FRAME_PIXELS;
  assign ptr_nxt  = (win_idx == IW'(N_CLIENTS - 1)) ? '0 : win_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (rst)     state <= START;
    else if (ce) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      START:     state_nxt = DRAW;
      DRAW:      if (&(done_latch | client_done)) state_nxt = FLUSH;
      FLUSH:     state_nxt = SWAP_WAIT;
      SWAP_WAIT: if (swap_ack) state_nxt = START;
      default:   state_nxt = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start      <= 1'b0;
      swap_req   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 1'b0;
      oob_err    <= 1'b0;
      ptr        <= '0;
      done_latch <= '0;
    end else begin
      // Pulses are re-derived every cycle so a ce=0 cycle never repeats them.
      start <= ce && (state == START);
      wr_en <= xfer && !oob;
      if (ce) begin
        if (xfer) begin
          ptr <= ptr_nxt;
          if (oob) begin
            oob_err <= 1'b1;
          end else begin
            wr_addr <= win_addr;
            wr_data <= win_data;
          end
        end
        if (state == START)     done_latch <= '0;
        else if (state == DRAW) done_latch <= done_latch | client_done;
        if (state == FLUSH)                      swap_req <= 1'b1;
        else if (state == SWAP_WAIT && swap_ack) swap_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_writer_arbiter.sv
// Directed vector bench for frame_writer_arbiter on a 5x2 frame with three clients.
module tb_frame_writer_arbiter;

  localparam int H  = 5;
  localparam int V  = 2;
  localparam int N  = 3;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, ce, swap_ack;
  logic [N-1:0]  client_req, client_data, client_done, client_gnt;
  logic [N*AW-1:0] client_addr;
  logic          start, swap_req, wr_en, wr_data, oob_err;
  logic [AW-1:0] wr_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst, ce, ack;
    logic [2:0]    req, data, done, gnt;
    logic [N*AW-1:0] addr;
    logic          en, wd, st, sw, oob;
    logic [AW-1:0] wa;
  } vec_t;

  vec_t vecs[$];

  frame_writer_arbiter #(
    .HOR_ACTIVE_PIXELS (H),
    .VER_ACTIVE_PIXELS (V),
    .N_CLIENTS         (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .client_req  (client_req),
    .client_addr (client_addr),
    .client_data (client_data),
    .client_done (client_done),
    .client_gnt  (client_gnt),
    .start       (start),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .oob_err     (oob_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int r, input int c, input int req, input int a0, input int a1,
                              input int a2, input int data, input int done, input int ack,
                              input int gnt, input int en, input int wa, input int wd,
                              input int st, input int sw, input int oob);
    vec_t v;
    v.rst  = r[0];
    v.ce   = c[0];
    v.req  = req[2:0];
    v.addr = {a2[AW-1:0], a1[AW-1:0], a0[AW-1:0]};
    v.data = data[2:0];
    v.done = done[2:0];
    v.ack  = ack[0];
    v.gnt  = gnt[2:0];
    v.en   = en[0];
    v.wa   = wa[AW-1:0];
    v.wd   = wd[0];
    v.st   = st[0];
    v.sw   = sw[0];
    v.oob  = oob[0];
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  // Inputs are applied just after a rising edge; grant is sampled before the next edge,
  // registered outputs just after it.
  task automatic run_vec(input vec_t v, input int row);
    rst         = v.rst;
    ce          = v.ce;
    client_req  = v.req;
    client_addr = v.addr;
    client_data = v.data;
    client_done = v.done;
    swap_ack    = v.ack;
    #1;
    chk("client_gnt", row, 32'(client_gnt), 32'(v.gnt));
    @(posedge clk);
    #1;
    chk("wr_en",    row, 32'(wr_en),    32'(v.en));
    chk("wr_addr",  row, 32'(wr_addr),  32'(v.wa));
    chk("wr_data",  row, 32'(wr_data),  32'(v.wd));
    chk("start",    row, 32'(start),    32'(v.st));
    chk("swap_req", row, 32'(swap_req), 32'(v.sw));
    chk("oob_err",  row, 32'(oob_err),  32'(v.oob));
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; swap_ack = 1'b0;
    client_req = '0; client_addr = '0; client_data = '0; client_done = '0;

    //            rst ce req    a0 a1 a2  data   done   ack   gnt    en wa wd st sw oob
    vecs.push_back(mk(1, 1, 'b000, 0, 0, 0, 'b000, 'b000, 0, 'b000, 0, 0, 0, 0, 0, 0)); // 0 reset
    vecs.push_back(mk(0, 0, 'b111, 1, 2, 3, 'b000, 'b000, 0, 'b000, 0, 0, 0, 0, 0, 0)); // 1 ce=0 in START
    vecs.push_back(mk(0, 1, 'b111, 1, 2, 3, 'b000, 'b000, 0, 'b000, 0, 0, 0, 1, 0, 0)); // 2 START
    vecs.push_back(mk(0, 1, 'b111, 1, 2, 3, 'b101, 'b000, 1, 'b001, 1, 1, 1, 0, 0, 0)); // 3 ack ignored
    vecs.push_back(mk(0, 1, 'b111, 4, 5, 6, 'b010, 'b000, 0, 'b010, 1, 5, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'b111, 7, 8, 9, 'b100, 'b000, 0, 'b100, 1, 9, 1, 0, 0, 0)); // 5 top valid addr
    vecs.push_back(mk(0, 1, 'b111, 0, 1, 2, 'b000, 'b000, 0, 'b001, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 'b111, 3, 3, 3, 'b111, 'b000, 0, 'b000, 0, 0, 0, 0, 0, 0)); // 7 ce=0 hole
    vecs.push_back(mk(0, 1, 'b111, 3, 3, 3, 'b111, 'b000, 0, 'b010, 1, 3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'b111, 1, 2, 4, 'b000, 'b000, 0, 'b100, 1, 4, 0, 0, 0, 0)); // 9 ptr stayed 2
    vecs.push_back(mk(0, 1, 'b001, 6, 0, 0, 'b001, 'b000, 0, 'b001, 1, 6, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'b101, 5, 0, 10,'b111, 'b000, 0, 'b100, 0, 6, 1, 0, 0, 1)); // 11 out of range
    vecs.push_back(mk(0, 1, 'b101, 5, 0, 15,'b000, 'b000, 0, 'b001, 1, 5, 0, 0, 0, 1)); // 12 grant consumed
    vecs.push_back(mk(0, 1, 'b111, 2, 3, 7, 'b010, 'b010, 0, 'b010, 1, 3, 1, 0, 0, 1)); // 13 done+req
    vecs.push_back(mk(0, 1, 'b111, 1, 4, 8, 'b100, 'b000, 0, 'b100, 1, 8, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 'b111, 1, 4, 8, 'b000, 'b000, 0, 'b001, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 'b010, 1, 4, 8, 'b111, 'b000, 0, 'b000, 0, 1, 0, 0, 0, 1)); // 16 latched client
    vecs.push_back(mk(0, 1, 'b011, 2, 5, 8, 'b001, 'b101, 0, 'b001, 1, 2, 1, 0, 0, 1)); // 17 all done
    vecs.push_back(mk(0, 1, 'b111, 2, 5, 8, 'b111, 'b000, 0, 'b000, 0, 2, 1, 0, 1, 1)); // 18 FLUSH
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 1, 'b111, 2, 5, 8, 'b111, 'b000, 0, 'b000, 0, 2, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 'b111, 2, 5, 8, 'b111, 'b000, 1, 'b000, 0, 2, 1, 0, 0, 1)); // 23 ack
    vecs.push_back(mk(0, 1, 'b111, 3, 4, 5, 'b111, 'b000, 0, 'b000, 0, 2, 1, 1, 0, 1)); // 24 START
    vecs.push_back(mk(0, 1, 'b111, 3, 4, 5, 'b111, 'b000, 0, 'b010, 1, 4, 1, 0, 0, 1)); // 25 latch cleared
    vecs.push_back(mk(0, 1, 'b000, 0, 0, 0, 'b000, 'b111, 0, 'b000, 0, 4, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 'b111, 0, 0, 0, 'b000, 'b000, 0, 'b000, 0, 4, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 'b111, 0, 0, 0, 'b000, 'b000, 1, 'b000, 0, 4, 1, 0, 0, 1)); // 28 immediate ack
    vecs.push_back(mk(0, 1, 'b000, 0, 0, 0, 'b000, 'b000, 0, 'b000, 0, 4, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 'b000, 0, 0, 0, 'b000, 'b000, 0, 'b000, 0, 4, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 'b000, 0, 0, 0, 'b000, 'b111, 0, 'b000, 0, 4, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 'b000, 0, 0, 0, 'b000, 'b000, 0, 'b000, 0, 4, 1, 0, 1, 1)); // 32 -> SWAP_WAIT
    vecs.push_back(mk(1, 1, 'b000, 0, 0, 0, 'b000, 'b000, 0, 'b000, 0, 0, 0, 0, 0, 0)); // 33 rst
    vecs.push_back(mk(0, 0, 'b111, 1, 2, 3, 'b110, 'b000, 0, 'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'b111, 1, 2, 3, 'b110, 'b000, 0, 'b000, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 'b111, 1, 2, 3, 'b110, 'b000, 0, 'b001, 1, 1, 0, 0, 0, 0)); // 36 ptr reset

    @(posedge clk);
    #1;

    for (int r = 0; r <= 8; r++) run_vec(vecs[r], r);

    // Lone requester: back-to-back grants to client 1; neighbours carry an out-of-range
    // address and inverted data so a wrong mux select would show up.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = mk(0, 1, 'b010, 15, i, 15, (i % 2 == 1) ? 'b010 : 'b101, 'b000, 0,
             'b010, 1, i, i % 2, 0, 0, 0);
      run_vec(v, 100 + i);
    end

    for (int r = 9; r < vecs.size(); r++) run_vec(vecs[r], r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
